// File: rtl/eight_bit_mux_arbiter.sv
// Four-source round-robin arbiter feeding a registered 8-bit 4:1 mux, with
// valid/ready handshake, no-bubble re-arbitration and an optional ready timeout.
module eight_bit_mux_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] d,
  input  logic       out_ready,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       err
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  localparam logic [3:0] TLAST = 4'(TIMEOUT - 1);

  state_t     r_state, w_state_n;
  logic [1:0] r_ptr, w_ptr_n;
  logic [3:0] r_tcnt, w_tcnt_n;
  logic [3:0] r_gnt, w_gnt_n;
  logic [1:0] r_sel, w_sel_n;
  logic [7:0] r_data, w_data_n;
  logic       r_valid, w_valid_n;
  logic       r_err, w_err_n;

  logic [1:0] w_base;
  logic       w_found;
  logic [1:0] w_idx;
  logic [7:0] w_mux;
  logic       w_accept;
  logic       w_tmo;

  assign w_accept = r_valid & out_ready;
  assign w_tmo    = (TIMEOUT != 0) && (r_tcnt == TLAST);

  // In SEND the scan base is the post-accept pointer so re-arbitration on the
  // accepting edge already sees the advanced round-robin position.
  assign w_base = (r_state == ST_SEND) ? r_sel + 2'd1 : r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_idx   = w_base;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_found && req[w_base + 2'(k)]) begin
        w_found = 1'b1;
        w_idx   = w_base + 2'(k);
      end
    end
  end

  always_comb begin
    case (w_idx)
      2'd0:    w_mux = a;
      2'd1:    w_mux = b;
      2'd2:    w_mux = c;
      default: w_mux = d;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_tcnt_n  = r_tcnt;
    w_gnt_n   = r_gnt;
    w_sel_n   = r_sel;
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_err_n   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_n = ST_SEND;
          w_gnt_n   = 4'b0001 << w_idx;
          w_sel_n   = w_idx;
          w_data_n  = w_mux;
          w_valid_n = 1'b1;
          w_tcnt_n  = '0;
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          w_ptr_n  = r_sel + 2'd1;
          w_tcnt_n = '0;
          if (w_found) begin
            w_gnt_n  = 4'b0001 << w_idx;
            w_sel_n  = w_idx;
            w_data_n = w_mux;
          end else begin
            w_state_n = ST_IDLE;
            w_gnt_n   = '0;
            w_valid_n = 1'b0;
          end
        end else if (w_tmo) begin
          w_state_n = ST_IDLE;
          w_ptr_n   = r_sel + 2'd1;
          w_gnt_n   = '0;
          w_valid_n = 1'b0;
          w_err_n   = 1'b1;
          w_tcnt_n  = '0;
        end else if (TIMEOUT != 0) begin
          w_tcnt_n = r_tcnt + 4'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_tcnt  <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_tcnt  <= w_tcnt_n;
      r_gnt   <= w_gnt_n;
      r_sel   <= w_sel_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_err   <= w_err_n;
    end
  end

  assign gnt       = r_gnt;
  assign s1        = r_sel[1];
  assign s0        = r_sel[0];
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign err       = r_err;
  assign ack       = r_gnt & {4{w_accept}};

endmodule

// File: tb/tb_eight_bit_mux_arbiter.sv
// Scoreboarded bench for eight_bit_mux_arbiter: default-timeout and TIMEOUT=4
// instances share stimulus; accepted transfers are checked against a queue.
module tb_eight_bit_mux_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic       out_ready;

  logic [3:0] gnt, ack, gnt4, ack4;
  logic       s1, s0, out_valid, err, s1_4, s0_4, out_valid4, err4;
  logic [7:0] out_data, out_data4;

  logic [15:0] obs, obs4;
  assign obs  = {gnt, s1, s0, out_data, out_valid, err};
  assign obs4 = {gnt4, s1_4, s0_4, out_data4, out_valid4, err4};

  eight_bit_mux_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt), .s1(s1), .s0(s0), .out_data(out_data),
    .out_valid(out_valid), .ack(ack), .err(err)
  );

  eight_bit_mux_arbiter #(.TIMEOUT(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt4), .s1(s1_4), .s0(s0_4), .out_data(out_data4),
    .out_valid(out_valid4), .ack(ack4), .err(err4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic [7:0] dat;
  } xfer_t;

  xfer_t sb[$];

  // Accepted transfers on the default instance are popped from the scoreboard.
  always @(negedge clk) begin
    if (!reset && ack !== 4'b0000) begin
      xfer_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL accept_unexpected: got gnt=%b sel=%0d data=%h, expected no accept",
                 gnt, {s1, s0}, out_data);
      end else begin
        e = sb.pop_front();
        if ({gnt, s1, s0, out_data} !== {e.g, e.s, e.dat} || ack !== e.g) begin
          errors++;
          $display("FAIL accept_xfer: got gnt=%b ack=%b sel=%0d data=%h, expected gnt=ack=%b sel=%0d data=%h",
                   gnt, ack, {s1, s0}, out_data, e.g, e.s, e.dat);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    req = '0;
    out_ready = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    req = 4'b1111;
    out_ready = 1'b1;
    step(1);
    checks++;
    if (obs !== 16'h0 || obs4 !== 16'h0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h ack=%b, expected 0000/0000 ack=0000", obs, obs4, ack);
    end
    apply_reset;
  endtask

  task automatic test_single;
    apply_reset;
    a = 8'h11; b = 8'h22; c = 8'hC3; d = 8'h44;
    req = 4'b0100; out_ready = 1'b1;
    sb.push_back(xfer_t'{4'b0100, 2'd2, 8'hC3});
    step();
    checks++;
    if (obs !== {4'b0100, 2'd2, 8'hC3, 1'b1, 1'b0} || ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %h ack=%b, expected %h ack=0100",
               obs, ack, {4'b0100, 2'd2, 8'hC3, 1'b1, 1'b0});
    end
    req = 4'b0000;
    step();
    checks++;
    if (obs !== {4'b0000, 2'd2, 8'hC3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_idle_hold: got %h, expected %h", obs, {4'b0000, 2'd2, 8'hC3, 1'b0, 1'b0});
    end
    req = 4'b1111;
    sb.push_back(xfer_t'{4'b1000, 2'd3, 8'h44});
    step();
    checks++;
    if (obs !== {4'b1000, 2'd3, 8'h44, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_ptr_next: got %h, expected %h", obs, {4'b1000, 2'd3, 8'h44, 1'b1, 1'b0});
    end
    req = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || gnt !== 4'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_done: got valid=%b gnt=%b pending=%0d, expected 0 0000 0",
               out_valid, gnt, sb.size());
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] dv[4];
    logic [3:0] oh;
    apply_reset;
    a = 8'hA1; b = 8'hB2; c = 8'hC3; d = 8'hD4;
    dv[0] = 8'hA1; dv[1] = 8'hB2; dv[2] = 8'hC3; dv[3] = 8'hD4;
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      sb.push_back(xfer_t'{oh, 2'(i % 4), dv[i % 4]});
    end
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      step();
      checks++;
      if (obs !== {oh, 2'(i % 4), dv[i % 4], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rr_grant%0d: got %h, expected %h", i, obs, {oh, 2'(i % 4), dv[i % 4], 1'b1, 1'b0});
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || gnt !== 4'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rr_done: got valid=%b gnt=%b pending=%0d, expected 0 0000 0",
               out_valid, gnt, sb.size());
    end
  endtask

  task automatic test_backpressure;
    apply_reset;
    a = 8'h5A; b = 8'hB2;
    req = 4'b0011; out_ready = 1'b0;
    sb.push_back(xfer_t'{4'b0001, 2'd0, 8'h5A});
    sb.push_back(xfer_t'{4'b0010, 2'd1, 8'hB2});
    step();
    a = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      checks++;
      if (obs !== {4'b0001, 2'd0, 8'h5A, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_frozen%0d: got %h, expected %h", k, obs, {4'b0001, 2'd0, 8'h5A, 1'b1, 1'b0});
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (obs !== {4'b0010, 2'd1, 8'hB2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bp_next_b: got %h, expected %h", obs, {4'b0010, 2'd1, 8'hB2, 1'b1, 1'b0});
    end
    req = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_done: got valid=%b pending=%0d, expected 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_timeout;
    apply_reset;
    a = 8'hA1; d = 8'hD4;
    req = 4'b1000; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (obs4 !== {4'b1000, 2'd3, 8'hD4, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL tmo_wait%0d: got %h, expected %h", k, obs4, {4'b1000, 2'd3, 8'hD4, 1'b1, 1'b0});
      end
    end
    req = 4'b1111;
    step();
    checks++;
    if (obs4 !== {4'b0000, 2'd3, 8'hD4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_abandon: got %h, expected %h", obs4, {4'b0000, 2'd3, 8'hD4, 1'b0, 1'b1});
    end
    step();
    checks++;
    if (obs4 !== {4'b0001, 2'd0, 8'hA1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tmo_next_src0: got %h, expected %h", obs4, {4'b0001, 2'd0, 8'hA1, 1'b1, 1'b0});
    end
    apply_reset;
  endtask

  task automatic test_abandon_accept;
    apply_reset;
    c = 8'hC3;
    req = 4'b0100; out_ready = 1'b0;
    sb.push_back(xfer_t'{4'b0100, 2'd2, 8'hC3});
    step(4);
    out_ready = 1'b1; req = 4'b0000;
    step();
    checks++;
    if (obs4 !== {4'b0000, 2'd2, 8'hC3, 1'b0, 1'b0} || obs !== obs4 || sb.size() != 0) begin
      errors++;
      $display("FAIL tmo_last_accept: got %h/%h pending=%0d, expected %h for both, 0 pending",
               obs4, obs, sb.size(), {4'b0000, 2'd2, 8'hC3, 1'b0, 1'b0});
    end
  endtask

  task automatic test_timeout_default;
    apply_reset;
    a = 8'h5A;
    req = 4'b0001; out_ready = 1'b0;
    step(15);
    checks++;
    if (obs !== {4'b0001, 2'd0, 8'h5A, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tmo15_hold: got %h, expected %h", obs, {4'b0001, 2'd0, 8'h5A, 1'b1, 1'b0});
    end
    step();
    checks++;
    if (obs !== {4'b0000, 2'd0, 8'h5A, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tmo15_abandon: got %h, expected %h", obs, {4'b0000, 2'd0, 8'h5A, 1'b0, 1'b1});
    end
    req = 4'b0000;
    step();
    checks++;
    if (obs !== {4'b0000, 2'd0, 8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tmo15_err_pulse: got %h, expected %h", obs, {4'b0000, 2'd0, 8'h5A, 1'b0, 1'b0});
    end
  endtask

  task automatic test_async_reset;
    apply_reset;
    a = 8'h5A; b = 8'hB2;
    req = 4'b1111; out_ready = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL areset_pre: got gnt=%b, expected 0001", gnt);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0 || obs4 !== 16'h0 || ack !== 4'b0) begin
      errors++;
      $display("FAIL areset_immediate: got %h/%h ack=%b, expected 0000/0000 ack=0000", obs, obs4, ack);
    end
    step(2);
    reset = 1'b0;
    req = 4'b0110; out_ready = 1'b1;
    sb.push_back(xfer_t'{4'b0010, 2'd1, 8'hB2});
    step();
    checks++;
    if (obs !== {4'b0010, 2'd1, 8'hB2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL areset_first_grant: got %h, expected %h", obs, {4'b0010, 2'd1, 8'hB2, 1'b1, 1'b0});
    end
    req = 4'b0000;
    step();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL areset_done: got valid=%b pending=%0d, expected 0 0", out_valid, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    step(2);
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_timeout;
    test_abandon_accept;
    test_timeout_default;
    test_async_reset;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
